// File: rtl/pe_accum_f32_pkg.sv
// Shared float32 field positions, FSM encoding and small helpers for the PE
// accumulator and its align/add datapath.
package pe_accum_f32_pkg;

    localparam int FP_SIGN    = 31;
    localparam int FP_EXP_MSB = 30;
    localparam int FP_EXP_LSB = 23;
    localparam int FP_MAN_MSB = 22;
    localparam int FP_MAN_LSB = 0;

    localparam logic [7:0]  FP_EXP_MAX = 8'd254;
    localparam logic [30:0] FP_SAT_MAG = 31'h7F7FFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // X is the larger-magnitude operand; my is already shifted into X's exponent.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mx;
        logic [23:0] my;
        logic        sub;
    } aligned_t;

    function automatic logic fp_is_zero(input logic [31:0] f);
        return (f[FP_EXP_MSB:FP_EXP_LSB] == 8'd0);
    endfunction

    function automatic logic [23:0] fp_mant(input logic [31:0] f);
        return {1'b1, f[FP_MAN_MSB:FP_MAN_LSB]};
    endfunction

endpackage

// File: rtl/pe_accum_f32_fp_align_add.sv
// Combinational operand ordering, exponent alignment and mantissa add/sub.
// The caller registers the aligned operands and the raw sum in separate cycles.
module fp_align_add
    import pe_accum_f32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  aligned_t    al,
    output logic        bypass,
    output logic [31:0] bypass_val,
    output aligned_t    al_o,
    output logic [24:0] sum
);

    logic        a_zero_s;
    logic        b_zero_s;
    logic        a_big_s;
    logic [31:0] x_s;
    logic [31:0] y_s;
    logic [7:0]  diff_s;
    logic [23:0] my_full_s;

    // Zero bypass, ordering by magnitude and right-shift alignment of Y.
    always_comb begin
        a_zero_s = fp_is_zero(a);
        b_zero_s = fp_is_zero(b);
        bypass   = a_zero_s | b_zero_s;
        if (a_zero_s) begin
            if (b_zero_s) begin
                bypass_val = 32'd0;
            end else begin
                bypass_val = b;
            end
        end else begin
            bypass_val = a;
        end

        a_big_s = (a[FP_EXP_MSB:FP_EXP_LSB] > b[FP_EXP_MSB:FP_EXP_LSB]) ||
                  ((a[FP_EXP_MSB:FP_EXP_LSB] == b[FP_EXP_MSB:FP_EXP_LSB]) &&
                   (a[FP_MAN_MSB:FP_MAN_LSB] >= b[FP_MAN_MSB:FP_MAN_LSB]));
        if (a_big_s) begin
            x_s = a;
            y_s = b;
        end else begin
            x_s = b;
            y_s = a;
        end

        diff_s    = x_s[FP_EXP_MSB:FP_EXP_LSB] - y_s[FP_EXP_MSB:FP_EXP_LSB];
        my_full_s = fp_mant(y_s);

        al_o.sign = x_s[FP_SIGN];
        al_o.exp  = x_s[FP_EXP_MSB:FP_EXP_LSB];
        al_o.mx   = fp_mant(x_s);
        al_o.sub  = x_s[FP_SIGN] ^ y_s[FP_SIGN];
        if (diff_s >= 8'd24) begin
            al_o.my = 24'd0;
        end else begin
            al_o.my = my_full_s >> diff_s;
        end
    end

    // mx >= my after ordering, so the subtraction never goes negative.
    always_comb begin
        if (al.sub) begin
            sum = {1'b0, al.mx} - {1'b0, al.my};
        end else begin
            sum = {1'b0, al.mx} + {1'b0, al.my};
        end
    end

endmodule

// File: rtl/pe_accum_f32.sv
// Sequential float32 accumulator: sums N_TERMS products through an iterative
// align/add/normalise datapath and offers the sum on a valid/ready port.
module pe_accum_f32
    import pe_accum_f32_pkg::*;
#(
    parameter int N_TERMS = 9,
    parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam logic signed [9:0] EXP_MAX_S = $signed({2'b00, FP_EXP_MAX});
    localparam logic signed [9:0] EXP_MIN_S = 10'sd1;

    state_t            state_r;
    state_t            state_nxt;
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    aligned_t          al_r;
    logic [24:0]       m_r;
    logic signed [9:0] exp_r;
    logic              sign_r;
    logic [31:0]       res_r;
    logic [31:0]       acc_r;
    logic [CNT_W-1:0]  count_r;

    logic              in_ready_r;
    logic              out_valid_r;
    logic [31:0]       out_data_r;
    logic [CNT_W-1:0]  out_count_r;

    logic              bypass_s;
    logic [31:0]       bypass_val_s;
    aligned_t          al_s;
    logic [24:0]       sum_s;
    logic              accept_s;
    logic              last_term_s;
    logic              norm_done_s;
    logic [31:0]       norm_res_s;
    logic [31:0]       acc_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              in_ready_nxt_s;
    logic              out_valid_nxt_s;
    logic [31:0]       out_data_nxt_s;
    logic [CNT_W-1:0]  out_count_nxt_s;

    fp_align_add u_align_add (
        .a          (a_r),
        .b          (b_r),
        .al         (al_r),
        .bypass     (bypass_s),
        .bypass_val (bypass_val_s),
        .al_o       (al_s),
        .sum        (sum_s)
    );

    assign accept_s    = in_valid & (state_r == ST_IDLE);
    assign last_term_s = ((count_r + CNT_W'(1)) == CNT_W'(N_TERMS));
    assign norm_done_s = (m_r[24:23] == 2'b01);

    // Final packing once the mantissa is normalised, with exponent range checks.
    always_comb begin
        if (m_r == 25'd0) begin
            norm_res_s = 32'd0;
        end else if (exp_r > EXP_MAX_S) begin
            norm_res_s = {sign_r, FP_SAT_MAG};
        end else if (exp_r < EXP_MIN_S) begin
            norm_res_s = 32'd0;
        end else begin
            norm_res_s = {sign_r, exp_r[7:0], m_r[22:0]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; an accepted product takes priority over flush.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt = ST_ALIGN;
                end else if (flush && (count_r != {CNT_W{1'b0}})) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                if (bypass_s) begin
                    state_nxt = ST_WRITE;
                end else begin
                    state_nxt = ST_ADD;
                end
            end
            ST_ADD:   state_nxt = ST_NORM;
            ST_NORM: begin
                if ((m_r == 25'd0) || norm_done_s) begin
                    state_nxt = ST_WRITE;
                end else begin
                    state_nxt = ST_NORM;
                end
            end
            ST_WRITE: begin
                if (last_term_s) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the port values are registered.
    always_comb begin
        acc_nxt_s   = acc_r;
        count_nxt_s = count_r;
        case (state_r)
            ST_WRITE: begin
                acc_nxt_s   = res_r;
                count_nxt_s = count_r + CNT_W'(1);
            end
            ST_DONE: begin
                if (out_ready) begin
                    acc_nxt_s   = 32'd0;
                    count_nxt_s = {CNT_W{1'b0}};
                end else begin
                    acc_nxt_s   = acc_r;
                    count_nxt_s = count_r;
                end
            end
            default: begin
                acc_nxt_s   = acc_r;
                count_nxt_s = count_r;
            end
        endcase

        in_ready_nxt_s  = (state_nxt == ST_IDLE);
        out_valid_nxt_s = (state_nxt == ST_DONE);
        if (state_nxt == ST_DONE) begin
            out_data_nxt_s  = acc_nxt_s;
            out_count_nxt_s = count_nxt_s;
        end else begin
            out_data_nxt_s  = 32'd0;
            out_count_nxt_s = {CNT_W{1'b0}};
        end
    end

    // Datapath registers; NORM shifts one bit per cycle until bit 23 is the leading one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            al_r    <= '{sign: 1'b0, exp: 8'd0, mx: 24'd0, my: 24'd0, sub: 1'b0};
            m_r     <= 25'd0;
            exp_r   <= 10'sd0;
            sign_r  <= 1'b0;
            res_r   <= 32'd0;
            acc_r   <= 32'd0;
            count_r <= {CNT_W{1'b0}};
        end else begin
            acc_r   <= acc_nxt_s;
            count_r <= count_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r <= acc_r;
                        b_r <= in_data;
                    end else begin
                        a_r <= a_r;
                        b_r <= b_r;
                    end
                end
                ST_ALIGN: begin
                    al_r  <= al_s;
                    res_r <= bypass_val_s;
                end
                ST_ADD: begin
                    m_r    <= sum_s;
                    exp_r  <= $signed({2'b00, al_r.exp});
                    sign_r <= al_r.sign;
                end
                ST_NORM: begin
                    if ((m_r == 25'd0) || norm_done_s) begin
                        res_r <= norm_res_s;
                    end else if (m_r[24]) begin
                        m_r   <= m_r >> 1;
                        exp_r <= exp_r + 10'sd1;
                    end else begin
                        m_r   <= m_r << 1;
                        exp_r <= exp_r - 10'sd1;
                    end
                end
                default: begin
                    res_r <= res_r;
                end
            endcase
        end
    end

    // Registered handshake and result ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            out_count_r <= {CNT_W{1'b0}};
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_count_r <= out_count_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_count = out_count_r;

endmodule
